// File: rtl/vdmem_ctrl.sv
// vdmem_ctrl: data-memory controller with one scalar port and one LANES-wide
// vector port that share a single word-addressed storage array.
//
// A vector operation is split into N = LANES/LPC groups of LPC lanes. Group 0
// is serviced on the accepting edge; groups 1..N-1 follow on consecutive
// edges while the FSM sits in VEC and raises busy to stall the core.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   s_valid / s_ready    scalar request handshake (s_ready only in IDLE)
//   s_we, s_addr, s_wdata  scalar write enable, byte address, write data
//   s_rvalid, s_rdata    one-cycle read-valid pulse; read data held until next read
//   v_valid / v_ready    vector request handshake (scalar wins a tie)
//   v_we, v_mask         vector write enable, per-lane enable mask
//   v_addr, v_wdata      per-lane byte addresses and write data
//   v_rvalid, v_rdata    one-cycle pulse after the last group; all lanes update together
//   busy                 vector operation still in progress
module vdmem_ctrl #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 256,
  parameter int LPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_we,
  input  logic [WIDTH-1:0] s_addr,
  input  logic [WIDTH-1:0] s_wdata,
  output logic             s_rvalid,
  output logic [WIDTH-1:0] s_rdata,
  input  logic             v_valid,
  output logic             v_ready,
  input  logic             v_we,
  input  logic [LANES-1:0] v_mask,
  input  logic [WIDTH-1:0] v_addr  [LANES],
  input  logic [WIDTH-1:0] v_wdata [LANES],
  output logic             v_rvalid,
  output logic [WIDTH-1:0] v_rdata [LANES],
  output logic             busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NGRP = LANES / LPC;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic {IDLE, VEC} state_t;

  // Byte address to word index; the low two bits and everything above the
  // array depth fall away, so addresses wrap modulo DEPTH words.
  function automatic logic [AW-1:0] word_idx(input logic [WIDTH-1:0] a);
    return AW'(a >> 2);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [GW-1:0]    grp_q, grp_d;
  logic             we_q, we_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] addr_q  [LANES];
  logic [WIDTH-1:0] addr_d  [LANES];
  logic [WIDTH-1:0] wdata_q [LANES];
  logic [WIDTH-1:0] wdata_d [LANES];
  logic [WIDTH-1:0] rbuf_q  [LANES];
  logic [WIDTH-1:0] rbuf_d  [LANES];
  logic             s_rvalid_q, s_rvalid_d;
  logic [WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic             v_rvalid_q, v_rvalid_d;
  logic [WIDTH-1:0] v_rdata_q [LANES];
  logic [WIDTH-1:0] v_rdata_d [LANES];

  // The "current operation" seen by the array this cycle: the live inputs on
  // the accepting edge (group 0), the latched request for later groups.
  logic             s_acc, v_acc;
  logic [AW-1:0]    s_idx;
  logic             op_act, op_we, last_grp, in_grp;
  logic [LANES-1:0] op_mask;
  logic [WIDTH-1:0] op_addr  [LANES];
  logic [WIDTH-1:0] op_wdata [LANES];
  logic [GW-1:0]    op_grp;
  logic [AW-1:0]    lane_idx [LANES];
  logic [LANES-1:0] lane_wen;

  always_comb begin
    s_ready = (state_q == IDLE);
    v_ready = (state_q == IDLE) && !s_valid;
    busy    = (state_q == VEC);
    s_acc   = s_valid && s_ready && !reset;
    v_acc   = v_valid && v_ready && !reset;
    s_idx   = word_idx(s_addr);

    if (state_q == IDLE) begin
      op_act   = v_acc;
      op_we    = v_we;
      op_mask  = v_mask;
      op_addr  = v_addr;
      op_wdata = v_wdata;
      op_grp   = '0;
    end else begin
      // Reset aborts an in-flight operation before its next group commits.
      op_act   = !reset;
      op_we    = we_q;
      op_mask  = mask_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_grp   = grp_q;
    end
    last_grp = (op_grp == GW'(NGRP - 1));

    in_grp   = 1'b0;
    lane_wen = '0;
    rbuf_d   = rbuf_q;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = word_idx(op_addr[l]);
      in_grp      = (op_grp == GW'(l / LPC));
      lane_wen[l] = op_act && op_we && op_mask[l] && in_grp;
      if (op_act && !op_we && in_grp)
        rbuf_d[l] = op_mask[l] ? mem[lane_idx[l]] : '0;
    end

    state_d = state_q;
    grp_d   = grp_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (v_acc) begin
      we_d    = v_we;
      mask_d  = v_mask;
      addr_d  = v_addr;
      wdata_d = v_wdata;
    end
    if (op_act) begin
      if (last_grp) begin
        state_d = IDLE;
        grp_d   = '0;
      end else begin
        state_d = VEC;
        grp_d   = op_grp + GW'(1);
      end
    end

    // The read buffer is published only once every group has been sampled.
    v_rvalid_d = op_act && !op_we && last_grp;
    v_rdata_d  = v_rvalid_d ? rbuf_d : v_rdata_q;

    s_rvalid_d = s_acc && !s_we;
    s_rdata_d  = s_rvalid_d ? mem[s_idx] : s_rdata_q;
  end

  // Storage: lanes commit in ascending order so the highest enabled lane wins
  // when several lanes of one group target the same word.
  always_ff @(posedge clk) begin
    if (s_acc && s_we)
      mem[s_idx] <= s_wdata;
    for (int l = 0; l < LANES; l++)
      if (lane_wen[l])
        mem[lane_idx[l]] <= op_wdata[l];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      s_rvalid_q <= 1'b0;
      s_rdata_q  <= '0;
      v_rvalid_q <= 1'b0;
      for (int l = 0; l < LANES; l++)
        v_rdata_q[l] <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      s_rvalid_q <= s_rvalid_d;
      s_rdata_q  <= s_rdata_d;
      v_rvalid_q <= v_rvalid_d;
      v_rdata_q  <= v_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    mask_q  <= mask_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

  assign s_rvalid = s_rvalid_q;
  assign s_rdata  = s_rdata_q;
  assign v_rvalid = v_rvalid_q;
  assign v_rdata  = v_rdata_q;

endmodule

// File: tb/tb_vdmem_ctrl.sv
// Bench for vdmem_ctrl: three instances with LPC = 1, 2 and 4 (LANES = 4).
// Stimulus tasks push expected read responses (data plus arrival cycle) into
// queues; monitors pop and compare whenever an rvalid pulse appears.
module tb_vdmem_ctrl;

  typedef struct packed { int cyc; logic [31:0] d; } sexp_t;
  typedef struct packed { int cyc; logic [3:0][31:0] d; } vexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_valid, s_we, s_off;
  logic [31:0] s_addr, s_wdata;
  logic        v_valid1, v_valid2, v_valid4, v_we;
  logic [3:0]  v_mask;
  logic [31:0] v_addr [4];
  logic [31:0] v_wdata [4];

  logic        s_ready1, s_ready2, s_ready4;
  logic        s_rvalid1, s_rvalid2, s_rvalid4;
  logic [31:0] s_rdata1, s_rdata2, s_rdata4;
  logic        v_ready1, v_ready2, v_ready4;
  logic        v_rvalid1, v_rvalid2, v_rvalid4;
  logic [31:0] v_rdata1 [4];
  logic [31:0] v_rdata2 [4];
  logic [31:0] v_rdata4 [4];
  logic        busy1, busy2, busy4;

  vdmem_ctrl #(.WIDTH(32), .LANES(4), .DEPTH(256), .LPC(1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rvalid(s_rvalid1), .s_rdata(s_rdata1),
    .v_valid(v_valid1), .v_ready(v_ready1), .v_we(v_we), .v_mask(v_mask),
    .v_addr(v_addr), .v_wdata(v_wdata), .v_rvalid(v_rvalid1), .v_rdata(v_rdata1),
    .busy(busy1));

  vdmem_ctrl #(.WIDTH(32), .LANES(4), .DEPTH(256), .LPC(2)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_off), .s_ready(s_ready2), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rvalid(s_rvalid2), .s_rdata(s_rdata2),
    .v_valid(v_valid2), .v_ready(v_ready2), .v_we(v_we), .v_mask(v_mask),
    .v_addr(v_addr), .v_wdata(v_wdata), .v_rvalid(v_rvalid2), .v_rdata(v_rdata2),
    .busy(busy2));

  vdmem_ctrl #(.WIDTH(32), .LANES(4), .DEPTH(256), .LPC(4)) dut4 (
    .clk(clk), .reset(reset), .s_valid(s_off), .s_ready(s_ready4), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rvalid(s_rvalid4), .s_rdata(s_rdata4),
    .v_valid(v_valid4), .v_ready(v_ready4), .v_we(v_we), .v_mask(v_mask),
    .v_addr(v_addr), .v_wdata(v_wdata), .v_rvalid(v_rvalid4), .v_rdata(v_rdata4),
    .busy(busy4));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  sexp_t sq[$];
  vexp_t vq1[$], vq2[$], vq4[$];
  sexp_t se;
  vexp_t ve1, ve2, ve4;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] pk(input logic [31:0] r [4]);
    return {r[3], r[2], r[1], r[0]};
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst)
      1:       return busy1;
      2:       return busy2;
      default: return busy4;
    endcase
  endfunction

  // Monitors: compare {arrival cycle, data} against the scoreboard head.
  always @(negedge clk) if (!reset && s_rvalid1) begin
    if (sq.size() == 0) chk("s_rvalid_unexpected", {32'(cyc), s_rdata1}, 0);
    else begin se = sq.pop_front(); chk("s_read", {32'(cyc), s_rdata1}, se); end
  end
  always @(negedge clk) if (!reset && v_rvalid1) begin
    if (vq1.size() == 0) chk("v1_rvalid_unexpected", {32'(cyc), pk(v_rdata1)}, 0);
    else begin ve1 = vq1.pop_front(); chk("v1_read", {32'(cyc), pk(v_rdata1)}, ve1); end
  end
  always @(negedge clk) if (!reset && v_rvalid2) begin
    if (vq2.size() == 0) chk("v2_rvalid_unexpected", {32'(cyc), pk(v_rdata2)}, 0);
    else begin ve2 = vq2.pop_front(); chk("v2_read", {32'(cyc), pk(v_rdata2)}, ve2); end
  end
  always @(negedge clk) if (!reset && v_rvalid4) begin
    if (vq4.size() == 0) chk("v4_rvalid_unexpected", {32'(cyc), pk(v_rdata4)}, 0);
    else begin ve4 = vq4.pop_front(); chk("v4_read", {32'(cyc), pk(v_rdata4)}, ve4); end
  end

  task automatic scal(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    @(negedge clk);
    chk("s_ready", s_ready1, 1);
    s_valid = 1'b1; s_we = we; s_addr = a; s_wdata = d;
    if (!we) sq.push_back('{cyc: cyc + 1, d: exp});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic vop(input int inst, input logic we, input logic [3:0] m,
                     input logic [3:0][31:0] a, input logic [3:0][31:0] w,
                     input logic [3:0][31:0] exp, input int n);
    int bc;
    bit done;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v_addr[i]  = a[i];
      v_wdata[i] = w[i];
    end
    v_we = we; v_mask = m;
    case (inst)
      1: begin v_valid1 = 1'b1; if (!we) vq1.push_back('{cyc: cyc + n, d: exp}); end
      2: begin v_valid2 = 1'b1; if (!we) vq2.push_back('{cyc: cyc + n, d: exp}); end
      default: begin v_valid4 = 1'b1; if (!we) vq4.push_back('{cyc: cyc + n, d: exp}); end
    endcase
    @(negedge clk);
    v_valid1 = 1'b0; v_valid2 = 1'b0; v_valid4 = 1'b0;
    bc = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy_of(inst)) begin bc++; @(negedge clk); end
      else done = 1'b1;
    end
    chk("busy_cycles", 32'(bc), 32'(n - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; s_off = 1'b0;
    s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    v_valid1 = 1'b0; v_valid2 = 1'b0; v_valid4 = 1'b0; v_we = 1'b0; v_mask = '0;
    for (int i = 0; i < 4; i++) begin v_addr[i] = '0; v_wdata[i] = '0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_s_ready", s_ready1, 1);
    chk("rst_v_ready", v_ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_s_rvalid", s_rvalid1, 0);
    chk("rst_v_rvalid", v_rvalid1, 0);
    chk("rst_s_rdata", s_rdata1, 0);
    chk("rst_v_rdata", pk(v_rdata1), 0);

    // Scalar write/read and address aliasing (0x410 wraps onto 0x10)
    scal(1'b1, 32'h10, 32'hDEADBEEF, 0);
    scal(1'b0, 32'h410, 0, 32'hDEADBEEF);
    scal(1'b0, 32'h10, 0, 32'hDEADBEEF);
    scal(1'b1, 32'h8, 32'h55, 0);

    // Masked vector write (lane 2 disabled), then reads with both masks
    vop(1, 1'b1, 4'b1011, {32'hC, 32'h8, 32'h4, 32'h0}, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 4);
    vop(1, 1'b0, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, 0, {32'd4, 32'h55, 32'd2, 32'd1}, 4);
    vop(1, 1'b0, 4'b1011, {32'hC, 32'h8, 32'h4, 32'h0}, 0, {32'd4, 32'h0, 32'd2, 32'd1}, 4);

    // Duplicate addresses: highest enabled lane wins
    vop(1, 1'b1, 4'b1111, {4{32'h20}}, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 4);
    scal(1'b0, 32'h20, 0, 32'hD);
    vop(1, 1'b1, 4'b0111, {4{32'h24}}, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 4);
    scal(1'b0, 32'h24, 0, 32'hC);

    // Simultaneous scalar and vector requests: scalar first, vector next cycle
    @(negedge clk);
    s_valid = 1'b1; s_we = 1'b0; s_addr = 32'h10;
    v_valid1 = 1'b1; v_we = 1'b0; v_mask = 4'b1111;
    for (int i = 0; i < 4; i++) v_addr[i] = 32'(i * 4);
    #1;
    chk("tie_v_ready", v_ready1, 0);
    sq.push_back('{cyc: cyc + 1, d: 32'hDEADBEEF});
    vq1.push_back('{cyc: cyc + 5, d: {32'd4, 32'h55, 32'd2, 32'd1}});
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("tie_v_ready_next", v_ready1, 1);
    @(negedge clk);
    v_valid1 = 1'b0;
    chk("tie_busy", busy1, 1);
    repeat (5) @(negedge clk);

    // Reset after group 1 of a 4-group write aborts lanes 2-3
    scal(1'b1, 32'h48, 32'h99, 0);
    scal(1'b1, 32'h4C, 32'h99, 0);
    @(negedge clk);
    v_valid1 = 1'b1; v_we = 1'b1; v_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      v_addr[i]  = 32'h40 + 32'(i * 4);
      v_wdata[i] = 32'h11 * 32'(i + 1);
    end
    @(negedge clk);
    v_valid1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy1, 0);
    scal(1'b0, 32'h40, 0, 32'h11);
    scal(1'b0, 32'h44, 0, 32'h22);
    scal(1'b0, 32'h48, 0, 32'h99);
    scal(1'b0, 32'h4C, 0, 32'h99);

    // LPC = 2: two groups, one busy cycle
    vop(2, 1'b1, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, {32'd8, 32'd7, 32'd6, 32'd5}, 0, 2);
    vop(2, 1'b0, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, 0, {32'd8, 32'd7, 32'd6, 32'd5}, 2);
    vop(2, 1'b0, 4'b0110, {32'hC, 32'h8, 32'h4, 32'h0}, 0, {32'd0, 32'd7, 32'd6, 32'd0}, 2);

    // LPC = 4: single group, no busy; same-group duplicates
    vop(4, 1'b1, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, {32'd8, 32'd7, 32'd6, 32'd5}, 0, 1);
    vop(4, 1'b0, 4'b0101, {32'hC, 32'h8, 32'h4, 32'h0}, 0, {32'd0, 32'd7, 32'd0, 32'd5}, 1);
    vop(4, 1'b1, 4'b1111, {4{32'h20}}, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 1);
    vop(4, 1'b0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h20}, 0, {32'h0, 32'h0, 32'h0, 32'hD}, 1);

    repeat (5) @(negedge clk);
    chk("s_queue_drained", 32'(sq.size()), 0);
    chk("v1_queue_drained", 32'(vq1.size()), 0);
    chk("v2_queue_drained", 32'(vq2.size()), 0);
    chk("v4_queue_drained", 32'(vq4.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdmem_ctrl.md
Name: vdmem_ctrl

Overview:
- Parametrised data-memory controller: one scalar port plus one LANES-wide vector port sharing a single word-addressed storage array.
- Successor to the fixed 4-lane, single-cycle data memory. Generalised in word width, depth, lane count and lanes serviced per cycle.
- Adds valid/ready handshakes, per-lane write masks, serialised multi-cycle vector access and a stall signal for the core.
- Sits between the core's MEM stage and the storage array.

Parameters:
- WIDTH, 32, data word width in bits; addresses are also WIDTH bits.
- LANES, 4, number of vector lanes.
- DEPTH, 256, storage depth in words; power of two.
- LPC, 1, lanes accessed per cycle; must divide LANES. N = LANES/LPC groups per vector operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  scalar request valid
- s_ready  out  1  scalar request accepted when s_valid && s_ready
- s_we  in  1  1 = write, 0 = read
- s_addr  in  WIDTH  byte address
- s_wdata  in  WIDTH  scalar write data
- s_rvalid  out  1  one-cycle pulse: scalar read data valid
- s_rdata  out  WIDTH  scalar read data
- v_valid  in  1  vector request valid
- v_ready  out  1  vector request accepted when v_valid && v_ready
- v_we  in  1  1 = write all masked lanes, 0 = read all lanes
- v_mask  in  LANES  per-lane enable; bit i gates lane i
- v_addr  in  WIDTH x [0:LANES-1]  per-lane byte addresses
- v_wdata  in  WIDTH x [0:LANES-1]  per-lane write data
- v_rvalid  out  1  one-cycle pulse: vector read data valid
- v_rdata  out  WIDTH x [0:LANES-1]  per-lane read data
- busy  out  1  vector operation in progress; core stall request

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Addressing: word index = addr[clog2(DEPTH)+1:2]. addr[1:0] is ignored. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, VEC.
  - s_ready = (state == IDLE).
  - v_ready = (state == IDLE) && !s_valid, so scalar wins simultaneous requests.
  - busy = (state == VEC).
- Scalar access:
  - Write stores on the acceptance edge.
  - Read samples the array on the acceptance edge. s_rvalid is high in the following cycle, with s_rdata held until the next read.
  - Scalar writes produce no s_rvalid.
- Vector acceptance and group timing:
  - The accepting edge latches v_we, v_mask, v_addr and v_wdata, then processes group 0 (lanes 0..LPC-1).
  - Groups g = 1..N-1 are processed on the next N-1 edges, in state VEC.
  - If N == 1, the FSM stays in IDLE.
- Vector read data: v_rvalid pulses in the cycle after the final group edge, i.e. 1 cycle after acceptance for N = 1 and N cycles after acceptance otherwise. All lanes update together at that point.
- Vector write masking: lanes with mask 0 do not write.
- Vector read masking: lanes with mask 0 return 0 in v_rdata.
- Vector writes produce no v_rvalid.
- Duplicate addresses in one vector write: lanes are committed in ascending order, so the highest enabled lane wins. Within a group, the higher lane also wins.
- Back-to-back: a new request may be accepted in the cycle v_rvalid or s_rvalid is high. A read issued after a write sees the written data.
- Reset: state to IDLE. s_rvalid, v_rvalid and busy go to 0. s_rdata and v_rdata go to 0. Any in-flight vector op is aborted and its remaining groups never write. Array contents are not cleared.
- Inputs are sampled only on acceptance. Changes to v_* while busy are ignored.

Test Plan:
- LANES=4, LPC=1. Scalar write 0xDEADBEEF at 0x10, then scalar read 0x10 → s_rvalid next cycle, s_rdata=0xDEADBEEF. The 0x10 and 0x410 addresses (DEPTH=256) alias to the same word.
- Vector write lanes to 0x0, 0x4, 0x8, 0xC, data 1..4, mask 4'b1011 → busy high for 3 cycles. A following vector read returns {1, 2, old, 4}, mask-0 lane = 0. v_rvalid arrives 4 cycles after acceptance.
- LPC=2: vector read of 4 lanes → busy for exactly 1 cycle, v_rvalid 2 cycles after acceptance. LPC=4: no busy, v_rvalid next cycle.
- Vector write with all lanes at address 0x20, data 0xA..0xD, mask all ones → scalar read 0x20 returns 0xD.
- s_valid and v_valid asserted together in IDLE → scalar accepted (v_ready=0). Vector accepted the following cycle.
- Assert reset after group 1 of a 4-group vector write → lanes 2–3 are unwritten, busy=0 in the next cycle, and pre-reset data from lanes 0–1 is readable after reset.
